idu_pipe_stage: RTL
===================

Name: idu_pipe_stage

Overview:
Pipelined, parametrised decode stage for the single-issue RV32 core; successor to the combinational decoder. Sits between the fetch unit and the EXU. Decodes an RV32I subset, reads an internal register file, and tracks pending writes in a scoreboard to stall on RAW hazards. Uses valid/ready handshakes on both sides and registers its output.

Parameters:
XLEN, 32, datapath and register width.
NREG, 32, architectural register count (16 = RV32E); address width AW = clog2(NREG).
TYPE_W, 12, width of the one-hot inst_type bus.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  PC of in_inst
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU consumes the bundle
out_type  out  TYPE_W  one-hot class
out_imm  out  XLEN  extended immediate
out_rs1_data  out  XLEN  operand 1
out_rs2_data  out  XLEN  operand 2
out_rd  out  AW  destination register
out_rd_wen  out  1  instruction writes rd (rd != 0)
out_pc  out  XLEN  registered in_pc
out_snpc  out  XLEN  out_pc + 4
wb_en  in  1  write-back strobe
wb_addr  in  AW  write-back register
wb_data  in  XLEN  write-back data
flush  in  1  kill the output bundle (redirect)

Behaviour:
- Reset (async, rst=1): out_valid=0; all out_* registers 0; register file all 0; scoreboard all 0. in_ready is combinational and is 0 while rst=1.
- out_type bit map:
  - 0 addi, 1 jalr, 2 ebreak, 3 add, 4 lui
  - 5 auipc, 6 jal, 7 beq, 8 bne, 9 lw, 10 sw, 11 sub
  - Any other encoding gives all zeros (illegal). An illegal instruction still flows with rd_wen=0.
- Immediate formats, all sign-extended to XLEN:
  - I: addi, jalr, lw
  - S: sw
  - B: beq, bne
  - U: lui, auipc; inst[31:12] in the upper bits, low 12 bits zero
  - J: jal
  - Everything else: 0.
- Register use:
  - rs1 = inst[19:15], used by addi, jalr, add, sub, beq, bne, lw, sw.
  - rs2 = inst[24:20], used by add, sub, beq, bne, sw.
  - rd = inst[11:7]. out_rd_wen=1 only for addi, jalr, add, sub, lui, auipc, jal, lw with rd != 0.
  - If NREG=16, address bit 4 is ignored.
- Register file:
  - x0 reads 0; writes to x0 are discarded.
  - Write on the clk edge when wb_en=1.
  - Same-cycle bypass: if wb_en and wb_addr equals a read address (nonzero), the operand is wb_data.
- Scoreboard, one busy bit per register:
  - Set for out_rd when an instruction with rd_wen is accepted.
  - Cleared for wb_addr when wb_en=1.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard: hazard=1 if a used rs (nonzero) has its busy bit set and is not being cleared by wb_en this cycle.
- Handshake:
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - Accept when in_valid && in_ready. The output registers load on that edge, so latency is 1 cycle.
  - If out_valid && out_ready && !accept, out_valid clears.
  - While out_valid=1 && out_ready=0, all out_* stay stable.
- Flush:
  - Has priority. Clears out_valid.
  - If the killed bundle had rd_wen, its busy bit is cleared.
  - Nothing is accepted in the flush cycle.
- Write-back arriving during a stall: operands are read fresh on the accept cycle. Stale data is never latched.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) at pc=0x80000000 -> next cycle: out_valid=1, type bit0, imm=5, rd=1, rd_wen=1, snpc=0x80000004.
- Back-to-back add x3,x1,x2 after addi x1 with no write-back -> in_ready=0. Then wb_en x1=5 -> accept in the same cycle, rs1_data=5 (bypass), busy[1] cleared.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0. Release -> next instruction is accepted on the release cycle.
- Decode sw / beq / jal / lui with negative offsets -> S imm=-4 (0xFFFFFFFC), B imm=-8, J imm=-2048, lui 0x12345 gives imm=0x12345000.
- flush while out_valid with rd=5 -> out_valid=0 next cycle, busy[5]=0, in_ready=0 in the flush cycle.
- Assert rst mid-stall with busy bits set -> out_valid=0 and scoreboard 0 immediately. 0x00000000 afterwards -> type=0, rd_wen=0.

Source files
------------

// File: rtl/idu_pipe_stage.sv
// rtl/idu_pipe_stage.sv - pipelined RV32I-subset decode stage with register file and RAW scoreboard
module idu_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int TYPE_W = 12,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TYPE_W-1:0] out_type,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [AW-1:0]     out_rd,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_snpc,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush
);

  localparam int T_ADDI = 0, T_JALR = 1, T_EBREAK = 2, T_ADD = 3, T_LUI = 4, T_AUIPC = 5;
  localparam int T_JAL = 6, T_BEQ = 7, T_BNE = 8, T_LW = 9, T_SW = 10, T_SUB = 11;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  logic [AW-1:0] rs1_addr, rs2_addr, dec_rd;
  assign rs1_addr = in_inst[15 +: AW];
  assign rs2_addr = in_inst[20 +: AW];
  assign dec_rd   = in_inst[7 +: AW];

  logic [TYPE_W-1:0] dec_type;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   dec_imm;
  logic              use_rs1, use_rs2, dec_wen;

  always_comb begin
    dec_type           = '0;
    dec_type[T_ADDI]   = opcode == 7'b0010011 && funct3 == 3'b000;
    dec_type[T_JALR]   = opcode == 7'b1100111 && funct3 == 3'b000;
    dec_type[T_EBREAK] = in_inst == 32'h0010_0073;
    dec_type[T_ADD]    = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000;
    dec_type[T_LUI]    = opcode == 7'b0110111;
    dec_type[T_AUIPC]  = opcode == 7'b0010111;
    dec_type[T_JAL]    = opcode == 7'b1101111;
    dec_type[T_BEQ]    = opcode == 7'b1100011 && funct3 == 3'b000;
    dec_type[T_BNE]    = opcode == 7'b1100011 && funct3 == 3'b001;
    dec_type[T_LW]     = opcode == 7'b0000011 && funct3 == 3'b010;
    dec_type[T_SW]     = opcode == 7'b0100011 && funct3 == 3'b010;
    dec_type[T_SUB]    = opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000;
  end

  always_comb begin
    imm32 = '0;
    if (dec_type[T_ADDI] || dec_type[T_JALR] || dec_type[T_LW])
      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (dec_type[T_SW])
      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (dec_type[T_BEQ] || dec_type[T_BNE])
      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (dec_type[T_LUI] || dec_type[T_AUIPC])
      imm32 = {in_inst[31:12], 12'b0};
    else if (dec_type[T_JAL])
      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  end
  assign dec_imm = XLEN'(imm32);

  assign use_rs1 = dec_type[T_ADDI] | dec_type[T_JALR] | dec_type[T_ADD] | dec_type[T_SUB] |
                   dec_type[T_BEQ]  | dec_type[T_BNE]  | dec_type[T_LW]  | dec_type[T_SW];
  assign use_rs2 = dec_type[T_ADD] | dec_type[T_SUB] | dec_type[T_BEQ] | dec_type[T_BNE] |
                   dec_type[T_SW];
  assign dec_wen = (dec_type[T_ADDI] | dec_type[T_JALR] | dec_type[T_ADD] | dec_type[T_SUB] |
                    dec_type[T_LUI]  | dec_type[T_AUIPC] | dec_type[T_JAL] | dec_type[T_LW]) &&
                   dec_rd != '0;

  // Register file; the write-back bypass makes a same-cycle write visible to the accepting instruction
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] rs1_data, rs2_data;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = (wb_en && wb_addr == rs1_addr) ? wb_data : regs_q[rs1_addr];
    if (rs2_addr != '0) rs2_data = (wb_en && wb_addr == rs2_addr) ? wb_data : regs_q[rs2_addr];
  end

  logic [NREG-1:0] busy_q, busy_d;
  logic            hazard, accept;
  logic            rs1_blocked, rs2_blocked;

  assign rs1_blocked = use_rs1 && rs1_addr != '0 && busy_q[rs1_addr] &&
                       !(wb_en && wb_addr == rs1_addr);
  assign rs2_blocked = use_rs2 && rs2_addr != '0 && busy_q[rs2_addr] &&
                       !(wb_en && wb_addr == rs2_addr);
  assign hazard   = rs1_blocked || rs2_blocked;

  logic out_valid_q, out_valid_d;
  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  logic [TYPE_W-1:0] out_type_q, out_type_d;
  logic [XLEN-1:0]   out_imm_q, out_imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d, out_snpc_q, out_snpc_d;
  logic [AW-1:0]     out_rd_q, out_rd_d;
  logic              out_rd_wen_q, out_rd_wen_d;

  // Set beats clear: the accept update is applied last
  always_comb begin
    busy_d = busy_q;
    if (flush && out_valid_q && out_rd_wen_q) busy_d[out_rd_q] = 1'b0;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (accept && dec_wen) busy_d[dec_rd] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_type_d   = out_type_q;
    out_imm_d    = out_imm_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    out_rd_d     = out_rd_q;
    out_rd_wen_d = out_rd_wen_q;
    out_pc_d     = out_pc_q;
    out_snpc_d   = out_snpc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_type_d   = dec_type;
      out_imm_d    = dec_imm;
      rs1_data_d   = rs1_data;
      rs2_data_d   = rs2_data;
      out_rd_d     = dec_rd;
      out_rd_wen_d = dec_wen;
      out_pc_d     = in_pc;
      out_snpc_d   = in_pc + XLEN'(4);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_type_q   <= '0;
      out_imm_q    <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      out_rd_q     <= '0;
      out_rd_wen_q <= 1'b0;
      out_pc_q     <= '0;
      out_snpc_q   <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_type_q   <= out_type_d;
      out_imm_q    <= out_imm_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      out_rd_q     <= out_rd_d;
      out_rd_wen_q <= out_rd_wen_d;
      out_pc_q     <= out_pc_d;
      out_snpc_q   <= out_snpc_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_type     = out_type_q;
  assign out_imm      = out_imm_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_rd       = out_rd_q;
  assign out_rd_wen   = out_rd_wen_q;
  assign out_pc       = out_pc_q;
  assign out_snpc     = out_snpc_q;

endmodule
